piso_serializer: RTL and testbench

- Parallel-in, serial-out transmitter. Takes a parallel word over a valid/ready handshake and shifts it out one bit per clock.
- Drives a matching serial-in/parallel-out receiver at the far end of the link.
- A one-entry holding buffer lets back-to-back words stream with no idle bit between frames.
- Sits between the parallel register bank and the serial link.

---
 rtl/piso_serializer.sv | 103 ++++++++++
 tb/tb_piso_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word hold buffer.
// Streams back-to-back words with no idle bit between frames.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;
  logic             accept;
  logic             last;
  logic             head;

  assign in_ready = rst & ~hold_full;
  assign accept   = in_valid & in_ready;
  assign last     = (state == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      shreg     <= shreg_nx;
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    shreg_nx     = shreg;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_nx = pin;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        shreg_nx = MSB_FIRST ? (shreg << 1)
                             : (shreg >> 1);
        cnt_nx   = cnt + CW'(1);
        if (last) begin
          cnt_nx = '0;
          // Held word wins; in_ready is low then.
          if (hold_full) begin
            shreg_nx     = hold;
            hold_full_nx = 1'b0;
          end else if (accept) begin
            shreg_nx = pin;
          end else begin
            state_nx = IDLE;
          end
        end else if (accept) begin
          hold_nx      = pin;
          hold_full_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign head = MSB_FIRST ? shreg[WIDTH-1]
                          : shreg[0];

  assign busy        = (state == SHIFT);
  assign sout_valid  = busy;
  assign sout        = busy & head;
  assign frame_start = busy && (cnt == '0);
  assign done        = last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer.
// Covers both bit orders, streaming and reset abort.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] pin_m, pin_l;
  logic       vld_m, vld_l;
  logic       rdy_m, rdy_l;
  logic       so_m, so_l;
  logic       sv_m, sv_l;
  logic       fs_m, fs_l;
  logic       dn_m, dn_l;
  logic       bz_m, bz_l;

  int passed;
  int total;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst),
    .pin(pin_m), .in_valid(vld_m),
    .in_ready(rdy_m), .sout(so_m),
    .sout_valid(sv_m), .frame_start(fs_m),
    .done(dn_m), .busy(bz_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst),
    .pin(pin_l), .in_valid(vld_l),
    .in_ready(rdy_l), .sout(so_l),
    .sout_valid(sv_l), .frame_start(fs_l),
    .done(dn_l), .busy(bz_l)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    vld_m = 1'b1;
    pin_m = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({rdy_m, sv_m, so_m, bz_m} !== 4'b0000)
        $display("FAIL reset[%0d] rdy/sv/so/bz=%b want 0000",
                 i, {rdy_m, sv_m, so_m, bz_m});
      else passed++;
    end
    vld_m = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    total++;
    if (sv_m !== 1'b0 || rdy_m !== 1'b1)
      $display("FAIL reset_noaccept sv=%b rdy=%b want 0 1",
               sv_m, rdy_m);
    else passed++;
  endtask

  task automatic test_single_msb();
    logic [7:0] exp;
    exp   = 8'b1010_0101;
    pin_m = 8'hA5;
    vld_m = 1'b1;
    tick();
    vld_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (so_m !== exp[7-i] || sv_m !== 1'b1 ||
          fs_m !== (i == 0) || dn_m !== (i == 7))
        $display("FAIL msb_bit%0d so=%b sv=%b fs=%b dn=%b want %b 1 %b %b",
                 i, so_m, sv_m, fs_m, dn_m,
                 exp[7-i], (i == 0), (i == 7));
      else passed++;
      tick();
    end
    total++;
    if ({sv_m, bz_m, so_m} !== 3'b000)
      $display("FAIL msb_after sv/bz/so=%b want 000",
               {sv_m, bz_m, so_m});
    else passed++;
  endtask

  task automatic test_single_lsb();
    logic [7:0] exp;
    exp   = 8'b1000_0000;
    pin_l = 8'h01;
    vld_l = 1'b1;
    tick();
    vld_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (so_l !== exp[7-i] || sv_l !== 1'b1)
        $display("FAIL lsb_bit%0d so=%b sv=%b want %b 1",
                 i, so_l, sv_l, exp[7-i]);
      else passed++;
      tick();
    end
    total++;
    if (sv_l !== 1'b0)
      $display("FAIL lsb_after sv=%b want 0", sv_l);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [3];
    logic [23:0] stream;
    logic        acc;
    logic        er;
    int          widx;
    words[0] = 8'h0F;
    words[1] = 8'hF0;
    words[2] = 8'h3C;
    stream   = 24'h0F_F0_3C;
    widx  = 0;
    vld_m = 1'b1;
    pin_m = words[0];
    acc   = rdy_m;
    tick();
    if (acc) widx++;
    for (int k = 1; k <= 25; k++) begin
      if (k <= 24) begin
        er = (k == 1) || (k == 9) || (k >= 17);
        total++;
        if (sv_m !== 1'b1 || so_m !== stream[24-k] ||
            fs_m !== ((k % 8) == 1) || rdy_m !== er)
          $display("FAIL b2b_c%0d sv=%b so=%b fs=%b rdy=%b want 1 %b %b %b",
                   k, sv_m, so_m, fs_m, rdy_m,
                   stream[24-k], ((k % 8) == 1), er);
        else passed++;
      end else begin
        total++;
        if (sv_m !== 1'b0)
          $display("FAIL b2b_end sv=%b want 0", sv_m);
        else passed++;
      end
      vld_m = (widx < 3);
      pin_m = (widx < 3) ? words[widx] : 8'h00;
      acc   = vld_m && rdy_m;
      tick();
      if (acc) widx++;
    end
    vld_m = 1'b0;
    total++;
    if (widx !== 3)
      $display("FAIL b2b_accepts got=%0d want 3", widx);
    else passed++;
  endtask

  task automatic test_last_edge_accept();
    logic [7:0] exp;
    exp   = 8'b1100_0011;
    pin_m = 8'h81;
    vld_m = 1'b1;
    tick();
    vld_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        total++;
        if (dn_m !== 1'b1 || rdy_m !== 1'b1)
          $display("FAIL last_edge dn=%b rdy=%b want 1 1",
                   dn_m, rdy_m);
        else passed++;
        vld_m = 1'b1;
        pin_m = 8'hC3;
      end
      tick();
      vld_m = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (sv_m !== 1'b1 || so_m !== exp[7-i] ||
          fs_m !== (i == 0))
        $display("FAIL last_c3_bit%0d sv=%b so=%b fs=%b want 1 %b %b",
                 i, sv_m, so_m, fs_m, exp[7-i], (i == 0));
      else passed++;
      tick();
    end
    total++;
    if (sv_m !== 1'b0)
      $display("FAIL last_after sv=%b want 0", sv_m);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    exp   = 8'b1001_0110;
    pin_m = 8'hAA;
    vld_m = 1'b1;
    tick();
    pin_m = 8'h55;
    tick();
    vld_m = 1'b0;
    total++;
    if (rdy_m !== 1'b0)
      $display("FAIL mid_held rdy=%b want 0", rdy_m);
    else passed++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({rdy_m, sv_m, so_m, fs_m, dn_m, bz_m} !== 6'b0)
      $display("FAIL mid_reset outs=%b want 000000",
               {rdy_m, sv_m, so_m, fs_m, dn_m, bz_m});
    else passed++;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (sv_m !== 1'b0 || rdy_m !== 1'b1)
        $display("FAIL mid_idle%0d sv=%b rdy=%b want 0 1",
                 i, sv_m, rdy_m);
      else passed++;
    end
    pin_m = 8'h96;
    vld_m = 1'b1;
    tick();
    vld_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (sv_m !== 1'b1 || so_m !== exp[7-i])
        $display("FAIL mid_96_bit%0d sv=%b so=%b want 1 %b",
                 i, sv_m, so_m, exp[7-i]);
      else passed++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sv_m !== 1'b0)
        $display("FAIL mid_no55_%0d sv=%b want 0", i, sv_m);
      else passed++;
      tick();
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b0;
    pin_m  = 8'h00;
    pin_l  = 8'h00;
    vld_m  = 1'b0;
    vld_l  = 1'b0;
    passed = 0;
    total  = 0;
    test_reset();
    test_single_msb();
    test_single_lsb();
    test_back_to_back();
    test_last_edge_accept();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
